// File: rtl/cdc_wfifo.sv
// ---------------------------------------------------------------------------
// cdc_wfifo
//   Write-direction CDC data FIFO. The Saturn-side CDC logic pushes 16-bit
//   words into an internal circular FIFO. An Avalon-MM write master drains the
//   FIFO into SDRAM, one word per bus write, covering a block whose byte
//   address and byte size come from registers. The register and status layout
//   matches the read-direction FIFO, so firmware drives both blocks the same
//   way.
//
// Ports
//   avm_clk        system clock; every flop uses the rising edge
//   avm_reset      asynchronous, active-high reset
//   reg_fifo_ctrl  [0]=dma_start, [1]=dma_abort, [2]=fifo_reset (all levels)
//   reg_blk_addr   SDRAM byte address of the block, latched in LOAD
//   reg_blk_size   block size in bytes, latched in LOAD
//   reg_fifo_stat  {mstate[2:0], empty, full, usedw[10:0]}
//   wr_strobe      one-cycle push request for data_in
//   data_in        word to push
//   blk_dma_end    one-cycle pulse when a block completes
//   avm_addr       Avalon write byte address
//   avm_wr         Avalon write request
//   avm_wdata      Avalon write data
//   avm_wait       Avalon waitrequest
// ---------------------------------------------------------------------------
module cdc_wfifo #(
   parameter int AW = 10
) (
   input  logic        avm_clk,
   input  logic        avm_reset,
   input  logic [15:0] reg_fifo_ctrl,
   input  logic [31:0] reg_blk_addr,
   input  logic [15:0] reg_blk_size,
   output logic [15:0] reg_fifo_stat,
   input  logic        wr_strobe,
   input  logic [15:0] data_in,
   output logic        blk_dma_end,
   output logic [31:0] avm_addr,
   output logic        avm_wr,
   output logic [15:0] avm_wdata,
   input  logic        avm_wait
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_DATA = 3'd2,
      ST_FETCH     = 3'd3,
      ST_WR_WAIT   = 3'd4,
      ST_NEXT      = 3'd5,
      ST_END       = 3'd6
   } mstate_e;

   mstate_e     mstate_q;
   logic [31:0] avm_addr_q;
   logic        avm_wr_q;
   logic [15:0] avm_wdata_q;
   logic        blk_dma_end_q;
   logic [15:0] dma_count_q;

   logic [15:0] mem_q [0:(1<<AW)-1];
   logic [15:0] q_q;
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic [AW:0] diff_s;
   logic [10:0] usedw_s;
   logic        empty_s, full_s;
   logic        push_s, pop_s;
   logic        dma_start_s, dma_abort_s, fifo_rst_s;
   logic        unused_ctrl_s;

   assign dma_start_s   = reg_fifo_ctrl[0];
   assign dma_abort_s   = reg_fifo_ctrl[1];
   assign fifo_rst_s    = reg_fifo_ctrl[2];
   assign unused_ctrl_s = ^reg_fifo_ctrl[15:3];

   // Pointers carry one extra wrap bit so a completely full FIFO is not
   // mistaken for an empty one.
   assign diff_s  = wptr_q - rptr_q;
   assign usedw_s = 11'(diff_s);
   assign empty_s = (diff_s == {(AW+1){1'b0}});
   assign full_s  = (diff_s == {1'b1, {AW{1'b0}}});

   // Pop is asserted for the single WAIT_DATA cycle that finds data available.
   // A push while full or during fifo_reset is silently dropped.
   assign pop_s  = (mstate_q == ST_WAIT_DATA) && !dma_abort_s && !empty_s;
   assign push_s = wr_strobe && !full_s && !fifo_rst_s;

   // Next-state pointers; fifo_reset overrides any push or pop in that cycle.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (fifo_rst_s) begin
         wptr_d = {(AW+1){1'b0}};
         rptr_d = {(AW+1){1'b0}};
      end else begin
         if (push_s) begin
            wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            wptr_d = wptr_q;
         end
         if (pop_s) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
         end else begin
            rptr_d = rptr_q;
         end
      end
   end

   // FIFO pointer registers.
   always_ff @(posedge avm_clk or posedge avm_reset) begin
      if (avm_reset) begin
         wptr_q <= {(AW+1){1'b0}};
         rptr_q <= {(AW+1){1'b0}};
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage array with a synchronous read port (q valid the cycle after pop);
   // left unreset so it maps onto block RAM.
   always_ff @(posedge avm_clk) begin
      if (push_s) begin
         mem_q[wptr_q[AW-1:0]] <= data_in;
      end
      if (pop_s) begin
         q_q <= mem_q[rptr_q[AW-1:0]];
      end
   end

   // Avalon write master: one word per bus write, abort honoured only outside
   // the FETCH/WR_WAIT pair so an issued write always completes.
   always_ff @(posedge avm_clk or posedge avm_reset) begin
      if (avm_reset) begin
         mstate_q      <= ST_IDLE;
         avm_addr_q    <= 32'd0;
         avm_wr_q      <= 1'b0;
         avm_wdata_q   <= 16'd0;
         blk_dma_end_q <= 1'b0;
         dma_count_q   <= 16'd0;
      end else begin
         case (mstate_q)
            ST_IDLE: begin
               avm_wr_q      <= 1'b0;
               blk_dma_end_q <= 1'b0;
               if (dma_start_s && !dma_abort_s) begin
                  mstate_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               avm_addr_q  <= reg_blk_addr;
               dma_count_q <= reg_blk_size;
               if (dma_abort_s) begin
                  mstate_q <= ST_IDLE;
               end else if (reg_blk_size == 16'd0) begin
                  mstate_q <= ST_END;
               end else begin
                  mstate_q <= ST_WAIT_DATA;
               end
            end
            ST_WAIT_DATA: begin
               if (dma_abort_s) begin
                  mstate_q <= ST_IDLE;
               end else if (!empty_s) begin
                  mstate_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               avm_wdata_q <= q_q;
               avm_wr_q    <= 1'b1;
               mstate_q    <= ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
               // Saturating subtract: an odd byte count still costs a full word.
               if (!avm_wait) begin
                  avm_wr_q    <= 1'b0;
                  dma_count_q <= (dma_count_q <= 16'd2) ? 16'd0 : (dma_count_q - 16'd2);
                  mstate_q    <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               avm_addr_q <= avm_addr_q + 32'd2;
               if (dma_abort_s) begin
                  mstate_q <= ST_IDLE;
               end else if (dma_count_q == 16'd0) begin
                  mstate_q <= ST_END;
               end else begin
                  mstate_q <= ST_WAIT_DATA;
               end
            end
            ST_END: begin
               // Completion is reported only once firmware drops dma_start.
               if (!dma_start_s) begin
                  blk_dma_end_q <= 1'b1;
                  mstate_q      <= ST_IDLE;
               end
            end
            default: begin
               mstate_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign reg_fifo_stat = {mstate_q, empty_s, full_s, usedw_s};
   assign blk_dma_end   = blk_dma_end_q;
   assign avm_addr      = avm_addr_q;
   assign avm_wr        = avm_wr_q;
   assign avm_wdata     = avm_wdata_q;

endmodule

// File: tb/tb_cdc_wfifo.sv
// ---------------------------------------------------------------------------
// tb_cdc_wfifo
//   Directed and randomized bench for cdc_wfifo. A queue models the FIFO
//   contents; each block's expected bus writes are derived from the block
//   address, the byte size rounded up to words, and the queue order.
// ---------------------------------------------------------------------------
module tb_cdc_wfifo;

   logic        clk = 1'b0;
   logic        avm_reset;
   logic [15:0] ctrl;
   logic [31:0] blk_addr;
   logic [15:0] blk_size;
   logic [15:0] stat;
   logic        wr_strobe;
   logic [15:0] data_in;
   logic        blk_dma_end;
   logic [31:0] avm_addr;
   logic        avm_wr;
   logic [15:0] avm_wdata;
   logic        avm_wait;

   int total = 0;
   int bad   = 0;

   logic [15:0] mdl_q [$];
   logic [31:0] obs_addr_q [$];
   logic [15:0] obs_data_q [$];
   int          end_pulses = 0;

   cdc_wfifo #(.AW(10)) dut (
      .avm_clk       (clk),
      .avm_reset     (avm_reset),
      .reg_fifo_ctrl (ctrl),
      .reg_blk_addr  (blk_addr),
      .reg_blk_size  (blk_size),
      .reg_fifo_stat (stat),
      .wr_strobe     (wr_strobe),
      .data_in       (data_in),
      .blk_dma_end   (blk_dma_end),
      .avm_addr      (avm_addr),
      .avm_wr        (avm_wr),
      .avm_wdata     (avm_wdata),
      .avm_wait      (avm_wait)
   );

   always #5 clk = ~clk;

   // Bus monitor: a write completes on the edge where avm_wr=1 and avm_wait=0.
   always @(negedge clk) begin
      if (avm_wr && !avm_wait) begin
         obs_addr_q.push_back(avm_addr);
         obs_data_q.push_back(avm_wdata);
      end
      if (blk_dma_end) end_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [15:0] w);
      wr_strobe = 1'b1;
      data_in   = w;
      tick();
      wr_strobe = 1'b0;
      if (mdl_q.size() < 1024) mdl_q.push_back(w);
   endtask

   // Compare captured bus writes since base_w against the model.
   task automatic verify_writes(input string tag, input int base_w, input logic [31:0] addr, input int n);
      int          idx;
      logic [15:0] ed;
      logic [31:0] oa;
      logic [15:0] od;
      check({tag, "_nwr"}, 32'(obs_addr_q.size() - base_w), 32'(n));
      for (int k = 0; k < n; k++) begin
         idx = base_w + k;
         ed  = mdl_q.pop_front();
         oa  = (idx < obs_addr_q.size()) ? obs_addr_q[idx] : 32'hxxxx_xxxx;
         od  = (idx < obs_data_q.size()) ? obs_data_q[idx] : 16'hxxxx;
         check({tag, "_addr"}, oa, addr + 32'(2 * k));
         check({tag, "_data"}, 32'(od), 32'(ed));
      end
   endtask

   // Wait for END, drop start and expect exactly one completion pulse.
   task automatic finish_block(input string tag, input int base_e, input bit rnd_wait);
      int cyc = 0;
      while (stat[15:13] != 3'd6 && cyc < 3000) begin
         avm_wait = rnd_wait ? 1'($urandom_range(0, 1)) : 1'b0;
         tick();
         cyc++;
      end
      avm_wait = 1'b0;
      check({tag, "_end_reached"}, 32'(stat[15:13]), 32'd6);
      ctrl = 16'h0000;
      repeat (4) tick();
      check({tag, "_end_pulse"}, 32'(end_pulses - base_e), 32'd1);
      check({tag, "_idle"}, 32'(stat[15:13]), 32'd0);
   endtask

   task automatic run_block(input string tag, input logic [31:0] addr, input logic [15:0] size, input bit rnd_wait);
      int base_w, base_e;
      base_w   = obs_addr_q.size();
      base_e   = end_pulses;
      blk_addr = addr;
      blk_size = size;
      ctrl     = 16'h0001;
      finish_block(tag, base_e, rnd_wait);
      verify_writes(tag, base_w, addr, (int'(size) + 1) / 2);
      check({tag, "_usedw"}, 32'(stat[10:0]), 32'(mdl_q.size()));
   endtask

   initial begin
      int          base_w, base_e, cyc;
      logic [31:0] a;
      logic [15:0] sz;

      avm_reset = 1'b1;
      ctrl      = 16'h0000;
      blk_addr  = 32'd0;
      blk_size  = 16'd0;
      wr_strobe = 1'b0;
      data_in   = 16'd0;
      avm_wait  = 1'b0;
      repeat (3) tick();
      check("rst_stat", 32'(stat), 32'h0000_1000);
      check("rst_wr", 32'(avm_wr), 32'd0);
      check("rst_addr", avm_addr, 32'd0);
      check("rst_wdata", 32'(avm_wdata), 32'd0);
      check("rst_end", 32'(blk_dma_end), 32'd0);
      avm_reset = 1'b0;
      tick();

      // Basic 4-word block.
      push_word(16'h1111);
      push_word(16'h2222);
      push_word(16'h3333);
      push_word(16'h4444);
      check("t1_usedw4", 32'(stat), 32'h0000_0004);
      run_block("t1", 32'h0010_0000, 16'd8, 1'b0);
      check("t1_empty", 32'(stat), 32'h0000_1000);

      // Start on an empty FIFO, feed one word late.
      base_w   = obs_addr_q.size();
      base_e   = end_pulses;
      a        = $urandom;
      blk_addr = a;
      blk_size = 16'd2;
      ctrl     = 16'h0001;
      repeat (20) tick();
      check("t2_wait_state", 32'(stat[15:13]), 32'd2);
      check("t2_no_wr", 32'(avm_wr), 32'd0);
      push_word(16'($urandom));
      tick();
      check("t2_fetch_nowr", 32'(avm_wr), 32'd0);
      tick();
      check("t2_wr_at2", 32'(avm_wr), 32'd1);
      check("t2_wr_data", 32'(avm_wdata), 32'(mdl_q[0]));
      finish_block("t2", base_e, 1'b0);
      verify_writes("t2", base_w, a, 1);

      // Stall the second write for five cycles.
      for (int k = 0; k < 3; k++) push_word(16'($urandom));
      base_w   = obs_addr_q.size();
      base_e   = end_pulses;
      a        = $urandom;
      blk_addr = a;
      blk_size = 16'd6;
      ctrl     = 16'h0001;
      cyc = 0;
      while (!avm_wr && cyc < 100) begin tick(); cyc++; end
      check("t3_first_up", 32'(avm_wr), 32'd1);
      tick();
      check("t3_first_done", 32'(avm_wr), 32'd0);
      avm_wait = 1'b1;
      cyc = 0;
      while (!avm_wr && cyc < 100) begin tick(); cyc++; end
      for (int s = 0; s < 6; s++) begin
         if (s == 5) avm_wait = 1'b0;
         check("t3_stall_wr", 32'(avm_wr), 32'd1);
         check("t3_stall_addr", avm_addr, a + 32'd2);
         check("t3_stall_data", 32'(avm_wdata), 32'(mdl_q[1]));
         tick();
      end
      check("t3_released", 32'(avm_wr), 32'd0);
      finish_block("t3", base_e, 1'b0);
      verify_writes("t3", base_w, a, 3);

      // Overfill: the 1025th word is dropped; order survives; fifo_reset clears.
      for (int k = 0; k < 1025; k++) push_word(16'($urandom));
      check("t4_full", 32'(stat), 32'h0000_0C00);
      run_block("t4", 32'($urandom), 16'd4, 1'b0);
      check("t4_after2", 32'(stat), 32'h0000_03FE);
      ctrl = 16'h0004;
      tick();
      ctrl = 16'h0000;
      mdl_q.delete();
      check("t4_fifo_reset", 32'(stat), 32'h0000_1000);

      // Odd size rounds up; zero size ends with no writes.
      for (int k = 0; k < 3; k++) push_word(16'($urandom));
      run_block("t5_odd", 32'($urandom), 16'd5, 1'b0);
      run_block("t5_zero", 32'($urandom), 16'd0, 1'b0);

      // Randomized blocks with random waitrequest, including address wrap.
      for (int i = 0; i < 4; i++) begin
         sz = 16'($urandom_range(1, 12));
         a  = (i == 0) ? 32'hFFFF_FFFC : 32'($urandom);
         for (int k = 0; k < (int'(sz) + 1) / 2; k++) push_word(16'($urandom));
         run_block("rnd", a, sz, 1'b1);
      end

      // Abort during a stalled write: write completes, no completion pulse.
      push_word(16'($urandom));
      push_word(16'($urandom));
      base_w   = obs_addr_q.size();
      base_e   = end_pulses;
      a        = $urandom;
      blk_addr = a;
      blk_size = 16'd4;
      avm_wait = 1'b1;
      ctrl     = 16'h0001;
      cyc = 0;
      while (!avm_wr && cyc < 100) begin tick(); cyc++; end
      check("t6_in_wrwait", 32'(stat[15:13]), 32'd4);
      ctrl = 16'h0003;
      tick();
      tick();
      check("t6_hold_wr", 32'(avm_wr), 32'd1);
      check("t6_hold_state", 32'(stat[15:13]), 32'd4);
      avm_wait = 1'b0;
      tick();
      check("t6_next", 32'(stat[15:13]), 32'd5);
      check("t6_wr_low", 32'(avm_wr), 32'd0);
      tick();
      check("t6_idle", 32'(stat[15:13]), 32'd0);
      ctrl = 16'h0000;
      repeat (3) tick();
      check("t6_no_end", 32'(end_pulses - base_e), 32'd0);
      check("t6_still_idle", 32'(stat[15:13]), 32'd0);
      verify_writes("t6", base_w, a, 1);
      check("t6_usedw", 32'(stat[10:0]), 32'(mdl_q.size()));

      // Reset in the middle of a stalled write drops avm_wr at once.
      push_word(16'($urandom));
      blk_addr = $urandom;
      blk_size = 16'd2;
      avm_wait = 1'b1;
      ctrl     = 16'h0001;
      cyc = 0;
      while (!avm_wr && cyc < 100) begin tick(); cyc++; end
      check("t8_wr_up", 32'(avm_wr), 32'd1);
      avm_reset = 1'b1;
      ctrl      = 16'h0000;
      #1;
      check("t8_wr_drop", 32'(avm_wr), 32'd0);
      check("t8_addr_clr", avm_addr, 32'd0);
      check("t8_stat_clr", 32'(stat), 32'h0000_1000);
      mdl_q.delete();
      tick();
      avm_reset = 1'b0;
      avm_wait  = 1'b0;
      tick();
      check("t8_after", 32'(stat), 32'h0000_1000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
